mult_arbiter: RTL

Round-robin scheduler that shares one bit-serial fixed-point multiplier (`Mult`: 1 sign, 5 integer, 10 fraction bits) between `NREQ` requesters in the accelerator. It accepts a neuron/weight job through a valid/ready handshake and holds the neuron operand stable. It streams the weight word into the multiplier one bit per cycle over 16 enable cycles, captures the rounded product, and returns it with the requester ID through a valid/ready response port. It is the only driver of the multiplier's `input_neuron`, `Weight_bit` and `enable` pins.

---
 rtl/mult_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end for one shared bit-serial Q5.10 multiplier.
// A granted job is latched. Its weight is then streamed into the multiplier one
// bit per cycle: the magnitude goes first, MSB first, and the sign bit goes last.
// The product from the multiplier is captured and returned with the ID of the
// requester that sent the job.
//
// Handshakes: a transfer happens on any clock edge where valid and ready are
// both high. On the request side, req_ready[g] is a one-cycle combinational
// accept that is asserted only in IDLE. On the response side, rsp_valid stays
// high and rsp_data/rsp_id stay stable until rsp_ready is seen.
module mult_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_neuron,
    input  logic [16*NREQ-1:0]   req_weight,
    output logic [15:0]          mult_neuron,
    output logic                 mult_weight_bit,
    output logic                 mult_enable,
    input  logic [15:0]          mult_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_data,
    output logic [15:0]          jobs_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [15:0]     weight_q, weight_d;
    logic [15:0]     neuron_q, neuron_d;
    logic            enable_q, enable_d;
    logic            wbit_q, wbit_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic [15:0]     jobs_done_q, jobs_done_d;

    logic [15:0]     neuron_arr [NREQ];
    logic [15:0]     weight_arr [NREQ];
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    cand_sum;
    logic            grant;

    // Unpack the flat operand buses into one word per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign neuron_arr[gi] = req_neuron[16*gi +: 16];
        assign weight_arr[gi] = req_weight[16*gi +: 16];
    end

    // Bit of the weight word sent at stream position c: the magnitude goes
    // MSB first (w[14] at c=0 down to w[0] at c=14), and the sign goes at c=15.
    function automatic logic weight_bit_at(input logic [15:0] w, input logic [3:0] c);
        logic [3:0] idx;
        idx = 4'd14 - c;
        return (c == 4'd15) ? w[15] : w[idx];
    endfunction

    // Round-robin scan: start just after the last grant and wrap modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_sum = {1'b0, last_grant_q} + (IDW+1)'(1) + (IDW+1)'(i);
            if (cand_sum >= (IDW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand_sum[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[IDW-1:0];
            end
        end
    end

    // A grant is possible only while idle; the accept pulse is combinational.
    always_comb begin
        grant     = (state_q == S_IDLE) && grant_found;
        req_ready = grant ? (NREQ'(1) << grant_idx) : '0;
    end

    // Next-state and next-output logic. Enable and the weight bit are
    // registered, so they describe the cycle that follows.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        weight_d     = weight_q;
        neuron_d     = neuron_q;
        enable_d     = 1'b0;
        wbit_d       = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        jobs_done_d  = jobs_done_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d      = S_RUN;
                    bitcnt_d     = 4'd0;
                    neuron_d     = neuron_arr[grant_idx];
                    weight_d     = weight_arr[grant_idx];
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    enable_d     = 1'b1;
                    wbit_d       = weight_bit_at(weight_arr[grant_idx], 4'd0);
                end
            end
            S_RUN: begin
                if (bitcnt_q == 4'd15) begin
                    state_d  = S_CAPTURE;
                    bitcnt_d = 4'd0;
                end else begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    enable_d = 1'b1;
                    wbit_d   = weight_bit_at(weight_q, bitcnt_q + 4'd1);
                end
            end
            S_CAPTURE: begin
                rsp_data_d  = mult_out;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    jobs_done_d = jobs_done_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bitcnt_q     <= 4'd0;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            weight_q     <= 16'd0;
            neuron_q     <= 16'd0;
            enable_q     <= 1'b0;
            wbit_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 16'd0;
            jobs_done_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            weight_q     <= weight_d;
            neuron_q     <= neuron_d;
            enable_q     <= enable_d;
            wbit_q       <= wbit_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            jobs_done_q  <= jobs_done_d;
        end
    end

    assign mult_neuron     = neuron_q;
    assign mult_weight_bit = wbit_q;
    assign mult_enable     = enable_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = id_q;
    assign rsp_data        = rsp_data_q;
    assign jobs_done       = jobs_done_q;

endmodule
